// File: rtl/data_mem_responder.sv
// Purpose: load/store responder in front of a single-port word RAM, with byte lanes, load extension and error checks.
// Latency: resp_valid_o pulses WAIT_CYCLES+2 edges after accept (errors: 1 edge); one request per WAIT_CYCLES+3 cycles.
// Backpressure: req_ready_o only in IDLE; requests while busy are ignored; responses cannot be stalled.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_RESP} state_t;

    state_t             state_q;
    logic [3:0]         cnt_q;
    logic               we_q;
    logic [2:0]         funct3_q;
    logic [IDX_W-1:0]   idx_q;
    logic [1:0]         off_q;
    logic [31:0]        wdata_q;
    logic               resp_valid_q;
    logic [31:0]        resp_rdata_q;
    logic               resp_err_q;
    logic [31:0]        mem_q [DEPTH_WORDS];

    logic               accept;
    logic               req_err_d;
    logic [31:0]        rd_word;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [31:0]        load_d;
    logic [3:0]         be_d;
    logic [31:0]        st_data_d;

    // Ready is only offered in IDLE and is forced low while reset is held, so reset beats an accept.
    assign req_ready_o  = (state_q == ST_IDLE) && !rst;
    assign accept       = req_valid_i && req_ready_o;

    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;

    // Classify the incoming request; the result is latched together with the request at accept.
    always_comb begin
        logic misalign;
        logic oor;
        logic illegal;
        misalign  = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                    ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
        oor       = (req_addr_i[31:2] >= 30'(DEPTH_WORDS));
        if (req_we_i)
            illegal = req_funct3_i[2] || (req_funct3_i == 3'b011);
        else
            illegal = (req_funct3_i == 3'b011) || (req_funct3_i == 3'b110) ||
                      (req_funct3_i == 3'b111);
        req_err_d = misalign || oor || illegal;
    end

    // Lane selection and extension of the addressed word for the latched request.
    always_comb begin
        rd_word = mem_q[idx_q];
        case (off_q)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = off_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (funct3_q)
            3'b000:  load_d = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_d = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_d = {24'h0, rd_byte};
            3'b101:  load_d = {16'h0, rd_half};
            default: load_d = rd_word;
        endcase
        case (funct3_q[1:0])
            2'b00: begin
                be_d      = 4'b0001 << off_q;
                st_data_d = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_d      = off_q[1] ? 4'b1100 : 4'b0011;
                st_data_d = {2{wdata_q[15:0]}};
            end
            default: begin
                be_d      = 4'b1111;
                st_data_d = wdata_q;
            end
        endcase
    end

    // RAM write port: a store commits its byte lanes on the edge that leaves ACCESS; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == ST_ACCESS) && we_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_d[i]) mem_q[idx_q][8*i +: 8] <= st_data_d[8*i +: 8];
            end
        end
    end

    // Request sequencer: IDLE -> WAIT -> ACCESS -> RESP, with errors jumping straight to RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            idx_q        <= '0;
            off_q        <= 2'b00;
            wdata_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        we_q     <= req_we_i;
                        funct3_q <= req_funct3_i;
                        idx_q    <= req_addr_i[IDX_W+1:2];
                        off_q    <= req_addr_i[1:0];
                        wdata_q  <= req_wdata_i;
                        if (req_err_d) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= 32'h0;
                            resp_err_q   <= 1'b1;
                        end else if (WAIT_CYCLES == 0) begin
                            state_q <= ST_ACCESS;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) state_q <= ST_ACCESS;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                ST_ACCESS: begin
                    state_q      <= ST_RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= we_q ? 32'h0 : load_d;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
